spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_pkg.sv | 18 +
 rtl/spi_slave_sync_edge.sv | 33 +++
 rtl/spi_slave.sv | 155 +++++++++++++++
 tb/tb_spi_slave.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding and line idle levels.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SHIFT   = 2'b01,
        ST_WAIT_CS = 2'b10
    } state_t;

    localparam logic SCLK_IDLE  = 1'b1;
    localparam logic CS_IDLE    = 1'b1;
    localparam logic MOSI_RESET = 1'b0;

    function automatic logic is_busy(input state_t st);
        return (st == ST_SHIFT) || (st == ST_WAIT_CS);
    endfunction

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Multi-flop synchronizer with edge detection on the synchronized level.
// STAGES must be at least 2.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              dly_r;

    // Synchronizer chain plus one delay flop used for edge detection
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sync_r <= {STAGES{RESET_VAL}};
            dly_r  <= RESET_VAL;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            dly_r  <= sync_r[STAGES-1];
        end
    end

    assign level = sync_r[STAGES-1];
    assign rise  = sync_r[STAGES-1] & ~dly_r;
    assign fall  = ~sync_r[STAGES-1] & dly_r;

endmodule

// File: rtl/spi_slave.sv
// SPI slave (clock idle high, sample on rising sclk, drive on falling sclk),
// oversampled by clk_in through synchronizers.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int SIZE        = 40,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            sclk_in,
    input  logic            cs_n_in,
    input  logic            serial_in,
    input  logic [SIZE-1:0] data_in,
    input  logic            load_in,
    output logic            serial_out,
    output logic [SIZE-1:0] data_out,
    output logic            valid_out,
    output logic            busy_out,
    output logic            frame_err_out
);

    localparam int CNT_W = $clog2(SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);

    logic sclk_level_unused_s, sclk_rise_s, sclk_fall_s;
    logic cs_level_s, cs_rise_s, cs_fall_s;
    logic [SYNC_STAGES-1:0] mosi_sync_r;

    state_t          state_r, next_state_s;
    logic [SIZE-1:0] hold_r, tx_shift_r, tx_next_s, rx_shift_r, data_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic            first_fall_r;
    logic            done_s, frame_err_s;
    logic            valid_r, frame_err_r, busy_r, serial_out_r;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SCLK_IDLE)) u_sclk_sync (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .din      (sclk_in),
        .level    (sclk_level_unused_s),
        .rise     (sclk_rise_s),
        .fall     (sclk_fall_s)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CS_IDLE)) u_cs_sync (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .din      (cs_n_in),
        .level    (cs_level_s),
        .rise     (cs_rise_s),
        .fall     (cs_fall_s)
    );

    // MOSI synchronizer, same depth as sclk so the sampled bit lines up with the edge
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            mosi_sync_r <= {SYNC_STAGES{MOSI_RESET}};
        end else begin
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], serial_in};
        end
    end

    // Next-state, transmit shifter and completion/error decode
    always_comb begin
        next_state_s = state_r;
        tx_next_s    = tx_shift_r;
        done_s       = 1'b0;
        frame_err_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    next_state_s = ST_SHIFT;
                    tx_next_s    = hold_r;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_r == CNT_FULL) begin
                    // cs_n may already be high when it rose together with the last sclk edge
                    done_s       = 1'b1;
                    next_state_s = cs_level_s ? ST_IDLE : ST_WAIT_CS;
                end else if (cs_rise_s && !(sclk_rise_s && (bit_cnt_r == CNT_LAST))) begin
                    frame_err_s  = 1'b1;
                    next_state_s = ST_IDLE;
                end else if (sclk_fall_s && !first_fall_r) begin
                    tx_next_s    = {tx_shift_r[SIZE-2:0], 1'b0};
                end else begin
                    tx_next_s    = tx_shift_r;
                end
            end
            ST_WAIT_CS: begin
                if (cs_rise_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT_CS;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath registers and registered outputs
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_r      <= ST_IDLE;
            hold_r       <= '0;
            tx_shift_r   <= '0;
            rx_shift_r   <= '0;
            bit_cnt_r    <= '0;
            first_fall_r <= 1'b0;
            data_r       <= '0;
            valid_r      <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
            serial_out_r <= 1'b1;
        end else begin
            state_r    <= next_state_s;
            tx_shift_r <= tx_next_s;
            if (load_in) begin
                hold_r <= data_in;
            end
            if ((state_r == ST_IDLE) && cs_fall_s) begin
                bit_cnt_r    <= '0;
                first_fall_r <= 1'b1;
            end else if ((state_r == ST_SHIFT) && (bit_cnt_r != CNT_FULL)) begin
                if (sclk_fall_s) begin
                    first_fall_r <= 1'b0;
                end
                if (sclk_rise_s) begin
                    rx_shift_r <= {rx_shift_r[SIZE-2:0], mosi_sync_r[SYNC_STAGES-1]};
                    bit_cnt_r  <= bit_cnt_r + CNT_W'(1);
                end
            end
            if (done_s) begin
                data_r <= rx_shift_r;
            end
            valid_r      <= done_s;
            frame_err_r  <= frame_err_s;
            busy_r       <= is_busy(next_state_s);
            serial_out_r <= (next_state_s == ST_SHIFT) ? tx_next_s[SIZE-1] : 1'b1;
        end
    end

    assign serial_out    = serial_out_r;
    assign data_out      = data_r;
    assign valid_out     = valid_r;
    assign busy_out      = busy_r;
    assign frame_err_out = frame_err_r;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural SPI master drives frames, a scoreboard queue
// holds expected completion/error events and a monitor checks them as they appear.
module tb_spi_slave;

    localparam int SIZE = 8;
    localparam int PH   = 5;

    logic            clk = 1'b0, rst_n = 1'b0, sclk = 1'b1, cs_n = 1'b1, mosi = 1'b0, load = 1'b0;
    logic [SIZE-1:0] din = '0;
    logic            serial_out, valid_out, busy_out, frame_err_out;
    logic [SIZE-1:0] data_out;

    typedef struct {
        bit              is_err;
        logic [SIZE-1:0] data;
    } exp_t;

    exp_t            exp_q[$];
    int              errors = 0, checks = 0;
    logic [SIZE-1:0] model_hold = '0, model_dout = '0;
    logic            prev_valid = 1'b0, prev_err = 1'b0;

    spi_slave #(.SIZE(SIZE), .SYNC_STAGES(2)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .sclk_in       (sclk),
        .cs_n_in       (cs_n),
        .serial_in     (mosi),
        .data_in       (din),
        .load_in       (load),
        .serial_out    (serial_out),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .busy_out      (busy_out),
        .frame_err_out (frame_err_out)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    // Monitor: pops an expectation whenever the DUT reports a completed or truncated frame
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (valid_out || frame_err_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: valid=%0b err=%0b with empty queue", valid_out, frame_err_out);
                end else begin
                    e = exp_q.pop_front();
                    check("event_is_err", {63'd0, frame_err_out}, {63'd0, e.is_err});
                    check("event_is_valid", {63'd0, valid_out}, {63'd0, !e.is_err});
                    if (!e.is_err) model_dout = e.data;
                    check("data_out", 64'(data_out), 64'(model_dout));
                end
            end
            if (valid_out && prev_valid) check("valid_one_cycle", 64'd1, 64'd0);
            if (frame_err_out && prev_err) check("err_one_cycle", 64'd1, 64'd0);
        end
        prev_valid = valid_out;
        prev_err   = frame_err_out;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [SIZE-1:0] v);
        din  = v;
        load = 1'b1;
        wait_clk(1);
        load = 1'b0;
        model_hold = v;
    endtask

    // Drives cs_n low and n sclk cycles; optional mid-frame load and cs_n rise on the last rising edge
    task automatic shift_bits(input logic [SIZE-1:0] word, input int n, input int load_at,
                              input logic [SIZE-1:0] load_val, input bit simul,
                              output logic [SIZE-1:0] miso);
        miso = '0;
        cs_n = 1'b0;
        wait_clk(PH);
        check("busy_in_frame", {63'd0, busy_out}, 64'd1);
        for (int i = 0; i < n; i++) begin
            sclk = 1'b0;
            mosi = word[SIZE-1-i];
            if (i == load_at) begin
                din  = load_val;
                load = 1'b1;
                wait_clk(1);
                load = 1'b0;
                model_hold = load_val;
                wait_clk(PH - 1);
            end else begin
                wait_clk(PH);
            end
            miso[SIZE-1-i] = serial_out;
            sclk = 1'b1;
            if (simul && (i == n - 1)) cs_n = 1'b1;
            wait_clk(PH);
        end
    endtask

    task automatic frame(input logic [SIZE-1:0] word, input int n, input int load_at,
                         input logic [SIZE-1:0] load_val, input bit simul);
        logic [SIZE-1:0] tx_exp, miso;
        exp_t e;
        tx_exp   = model_hold;
        e.is_err = (n != SIZE);
        e.data   = word;
        exp_q.push_back(e);
        shift_bits(word, n, load_at, load_val, simul, miso);
        cs_n = 1'b1;
        wait_clk(12);
        check("miso_word", 64'(miso >> (SIZE - n)), 64'(tx_exp >> (SIZE - n)));
        check("busy_after", {63'd0, busy_out}, 64'd0);
        check("miso_idle", {63'd0, serial_out}, 64'd1);
        check("events_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", {63'd0, valid_out}, 64'd0);
        check("rst_err", {63'd0, frame_err_out}, 64'd0);
        check("rst_busy", {63'd0, busy_out}, 64'd0);
        check("rst_miso", {63'd0, serial_out}, 64'd1);
        check("rst_data", 64'(data_out), 64'd0);
    endtask

    initial begin
        logic [SIZE-1:0] miso;
        int n;
        wait_clk(3);
        check_reset_outputs();
        rst_n = 1'b1;
        wait_clk(4);

        do_load(8'hA5);
        frame(8'h3C, SIZE, -1, '0, 1'b0);
        frame(SIZE'($urandom), SIZE, -1, '0, 1'b0);
        frame(8'h5A, 5, -1, '0, 1'b0);
        frame(SIZE'($urandom), SIZE, 4, 8'h0F, 1'b0);
        frame(SIZE'($urandom), SIZE, -1, '0, 1'b0);
        frame(8'hC3, SIZE, -1, '0, 1'b1);

        // Reset in the middle of a frame: no event, outputs return to reset values
        shift_bits(8'h96, 3, -1, '0, 1'b0, miso);
        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b1;
        wait_clk(3);
        check_reset_outputs();
        model_dout = '0;
        model_hold = '0;
        rst_n = 1'b1;
        wait_clk(5);
        frame(8'h69, SIZE, -1, '0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 1) == 1) do_load(SIZE'($urandom));
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, SIZE - 1)) : SIZE;
            frame(SIZE'($urandom), n, -1, '0, (n == SIZE) && ($urandom_range(0, 2) == 0));
        end

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
